// File: rtl/cflog_pkg.sv
// Shared definitions for the CF-Log writer: state encoding, default log
// geometry, entry width and the tag bit that marks repeat-count words.
// Optional loop compression is enabled by defining CFLOG_LOOP_COMPRESS_EN.
package cflog_pkg;

    localparam int          ENTRY_W             = 16;
    localparam logic [15:0] LOG_BASE_DEFAULT    = 16'hA100;
    localparam logic [15:0] LOG_SIZE_DEFAULT    = 16'h0040;
    localparam int          DST_TIMEOUT_DEFAULT = 8;

    // Code addresses are always even, so an odd word in the log is a count.
    localparam logic        CNT_TAG             = 1'b1;
    localparam logic [14:0] RPT_MAX             = 15'h7FFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DST = 3'd1,
        ST_WR_SRC   = 3'd2,
        ST_WR_DST   = 3'd3,
`ifdef CFLOG_LOOP_COMPRESS_EN
        ST_FULL     = 3'd4,
        ST_WR_CNT   = 3'd5
`else
        ST_FULL     = 3'd4
`endif
    } state_e;

    // Byte address of a log word index (16-bit modulo arithmetic).
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [15:0] idx);
        return base + {idx[14:0], 1'b0};
    endfunction

    // Repeat-count word: count in the upper 15 bits, tag in bit 0.
    function automatic logic [15:0] count_word(input logic [14:0] cnt);
        return {cnt, CNT_TAG};
    endfunction

endpackage

// File: rtl/cflog_dst_capture.sv
// Destination capture for a detected branch: while active, watches the PC
// for a move off the latched source address, or gives up after
// DST_TIMEOUT cycles and takes the current PC as the destination.
module cflog_dst_capture
    import cflog_pkg::*;
#(
    parameter int DST_TIMEOUT = DST_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               active_i,
    input  logic [ENTRY_W-1:0] pc_i,
    input  logic [ENTRY_W-1:0] src_i,
    output logic               dst_valid_o,
    output logic [ENTRY_W-1:0] dst_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(DST_TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic       hit;

    // The destination is known as soon as the PC moves or the wait expires.
    always_comb begin
        hit         = (pc_i != src_i) || (cnt_q == TIMEOUT_LAST);
        dst_valid_o = active_i && hit;
        dst_o       = pc_i;
    end

    // Cycle counter for the wait, cleared whenever a new capture begins.
    always_ff @(posedge clk) begin
        if (reset || start_i) begin
            cnt_q <= 8'd0;
        end else if (active_i && !hit) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/cflog_writer.sv
// CF-Log writer: turns each branch_detect pulse into a (source, destination)
// pair and writes it as two words into the log region through a single
// acked write port. Tracks the write pointer, flags a full log and lost
// events. Defining CFLOG_LOOP_COMPRESS_EN collapses repeats of the last
// logged pair into a count word written before the next differing pair.
module cflog_writer
    import cflog_pkg::*;
#(
    parameter logic [15:0] LOG_BASE    = LOG_BASE_DEFAULT,
    parameter logic [15:0] LOG_SIZE    = LOG_SIZE_DEFAULT,
    parameter int          DST_TIMEOUT = DST_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               branch_detect,
    input  logic [ENTRY_W-1:0] pc,
    input  logic               flush,
    output logic               log_wr_en,
    output logic [15:0]        log_addr,
    output logic [ENTRY_W-1:0] log_wdata,
    input  logic               log_wr_ack,
    output logic [15:0]        log_ptr,
    output logic               log_full,
    output logic               evt_lost,
    output logic               busy
);

    state_e             state_q;
    logic [ENTRY_W-1:0] src_q;
    logic [ENTRY_W-1:0] dst_q;
    logic [15:0]        ptr_q;
    logic [15:0]        addr_q;
    logic [ENTRY_W-1:0] wdata_q;
    logic               wr_en_q;
    logic               full_q;
    logic               lost_q;

    logic [16:0]        ptr_plus2;
    logic               has_room2;
    logic [15:0]        ptr_d;
    logic [15:0]        addr_d;
    logic               wr_accept;
    logic               cap_start;
    logic               cap_active;
    logic               dst_valid;
    logic [ENTRY_W-1:0] cap_dst;

`ifdef CFLOG_LOOP_COMPRESS_EN
    logic               last_valid_q;
    logic [ENTRY_W-1:0] last_src_q;
    logic [ENTRY_W-1:0] last_dst_q;
    logic [14:0]        rpt_q;
    logic [16:0]        ptr_plus3;
    logic               has_room3;
    logic               pair_repeat;
`endif

    // Pointer arithmetic and handshake qualifiers.
    always_comb begin
        ptr_plus2  = {1'b0, ptr_q} + 17'd2;
        has_room2  = (ptr_plus2 <= {1'b0, LOG_SIZE});
        ptr_d      = ptr_q + 16'd1;
        addr_d     = word_addr(LOG_BASE, ptr_d);
        wr_accept  = wr_en_q && log_wr_ack;
        cap_start  = (state_q == ST_IDLE) && branch_detect && !flush && has_room2;
        cap_active = (state_q == ST_WAIT_DST);
    end

`ifdef CFLOG_LOOP_COMPRESS_EN
    // A pair identical to the last one logged is only counted.
    always_comb begin
        ptr_plus3   = {1'b0, ptr_q} + 17'd3;
        has_room3   = (ptr_plus3 <= {1'b0, LOG_SIZE});
        pair_repeat = last_valid_q && (src_q == last_src_q) && (cap_dst == last_dst_q);
    end
`endif

    cflog_dst_capture #(
        .DST_TIMEOUT (DST_TIMEOUT)
    ) u_dst_capture (
        .clk         (clk),
        .reset       (reset),
        .start_i     (cap_start),
        .active_i    (cap_active),
        .pc_i        (pc),
        .src_i       (src_q),
        .dst_valid_o (dst_valid),
        .dst_o       (cap_dst)
    );

    // Write-sequencing FSM with registered port outputs; flush overrides all.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 16'd0;
            addr_q   <= LOG_BASE;
            wr_en_q  <= 1'b0;
            full_q   <= 1'b0;
            lost_q   <= 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
            last_valid_q <= 1'b0;
            rpt_q        <= 15'd0;
`endif
            if (reset) begin
                src_q   <= '0;
                dst_q   <= '0;
                wdata_q <= '0;
`ifdef CFLOG_LOOP_COMPRESS_EN
                last_src_q <= '0;
                last_dst_q <= '0;
`endif
            end
        end else begin
            // No queueing: any event outside IDLE is dropped and remembered.
            if (branch_detect && (state_q != ST_IDLE)) begin
                lost_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (branch_detect) begin
                        if (!has_room2) begin
                            state_q <= ST_FULL;
                            full_q  <= 1'b1;
                        end else begin
                            src_q   <= pc;
                            state_q <= ST_WAIT_DST;
                        end
                    end
                end

                ST_WAIT_DST: begin
                    if (dst_valid) begin
                        dst_q <= cap_dst;
`ifdef CFLOG_LOOP_COMPRESS_EN
                        if (pair_repeat) begin
                            state_q <= ST_IDLE;
                            if (rpt_q != RPT_MAX) begin
                                rpt_q <= rpt_q + 15'd1;
                            end
                        end else if ((rpt_q != 15'd0) && !has_room3) begin
                            state_q <= ST_FULL;
                            full_q  <= 1'b1;
                        end else begin
                            last_valid_q <= 1'b1;
                            last_src_q   <= src_q;
                            last_dst_q   <= cap_dst;
                            wr_en_q      <= 1'b1;
                            if (rpt_q != 15'd0) begin
                                state_q <= ST_WR_CNT;
                                wdata_q <= count_word(rpt_q);
                            end else begin
                                state_q <= ST_WR_SRC;
                                wdata_q <= src_q;
                            end
                        end
`else
                        state_q <= ST_WR_SRC;
                        wr_en_q <= 1'b1;
                        wdata_q <= src_q;
`endif
                    end
                end

`ifdef CFLOG_LOOP_COMPRESS_EN
                ST_WR_CNT: begin
                    if (wr_accept) begin
                        ptr_q   <= ptr_d;
                        addr_q  <= addr_d;
                        rpt_q   <= 15'd0;
                        wdata_q <= src_q;
                        state_q <= ST_WR_SRC;
                    end
                end
`endif

                ST_WR_SRC: begin
                    if (wr_accept) begin
                        ptr_q   <= ptr_d;
                        addr_q  <= addr_d;
                        wdata_q <= dst_q;
                        state_q <= ST_WR_DST;
                    end
                end

                ST_WR_DST: begin
                    if (wr_accept) begin
                        ptr_q   <= ptr_d;
                        addr_q  <= addr_d;
                        wr_en_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_FULL: begin
                    // Absorbing until flush or reset.
                    wr_en_q <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Port outputs come straight from registers.
    always_comb begin
        log_wr_en = wr_en_q;
        log_addr  = addr_q;
        log_wdata = wdata_q;
        log_ptr   = ptr_q;
        log_full  = full_q;
        evt_lost  = lost_q;
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_cflog_writer.sv
// Self-checking bench for cflog_writer: directed scenarios followed by
// randomized events, checked against a pair-level model of the log.
module tb_cflog_writer;

    localparam logic [15:0] BASE  = 16'hA100;
    localparam int          LSIZE = 8;
    localparam int          TMO   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_detect;
    logic [15:0] pc;
    logic        flush;
    logic        log_wr_en;
    logic [15:0] log_addr;
    logic [15:0] log_wdata;
    logic        log_wr_ack;
    logic [15:0] log_ptr;
    logic        log_full;
    logic        evt_lost;
    logic        busy;

    always #5 clk = ~clk;

    cflog_writer #(
        .LOG_BASE    (BASE),
        .LOG_SIZE    (16'(LSIZE)),
        .DST_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .branch_detect (branch_detect),
        .pc            (pc),
        .flush         (flush),
        .log_wr_en     (log_wr_en),
        .log_addr      (log_addr),
        .log_wdata     (log_wdata),
        .log_wr_ack    (log_wr_ack),
        .log_ptr       (log_ptr),
        .log_full      (log_full),
        .evt_lost      (evt_lost),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int evt_no = 0;

    // Reference model state: pointer, flags, accepted writes.
    int          m_ptr = 0;
    int          m_writes = 0;
    bit          m_full = 1'b0;
    bit          m_lost = 1'b0;
    logic [15:0] exp_q[$];
`ifdef CFLOG_LOOP_COMPRESS_EN
    bit          m_last_valid = 1'b0;
    logic [15:0] m_last_src = '0;
    logic [15:0] m_last_dst = '0;
    logic [14:0] m_rpt = '0;
`endif

    // Count every write the port actually accepts.
    always @(posedge clk) begin
        if (!reset && !flush && log_wr_en && log_wr_ack) begin
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of one pair: 0 = words to write in exp_q, 1 = repeat (nothing
    // written), 2 = not enough room once a count word is needed.
    task automatic model_pair(input logic [15:0] s, input logic [15:0] d, output int res);
        exp_q.delete();
        res = 0;
`ifdef CFLOG_LOOP_COMPRESS_EN
        if (m_last_valid && s == m_last_src && d == m_last_dst) begin
            if (m_rpt != 15'h7FFF) m_rpt = m_rpt + 15'd1;
            res = 1;
            return;
        end
        if (m_rpt != 0) begin
            if (m_ptr + 3 > LSIZE) begin
                m_full = 1'b1;
                res = 2;
                return;
            end
            exp_q.push_back({m_rpt, 1'b1});
            m_rpt = '0;
        end
        m_last_valid = 1'b1;
        m_last_src = s;
        m_last_dst = d;
`endif
        exp_q.push_back(s);
        exp_q.push_back(d);
    endtask

    task automatic model_flush();
        m_ptr = 0;
        m_full = 1'b0;
        m_lost = 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
        m_last_valid = 1'b0;
        m_rpt = '0;
`endif
    endtask

    task automatic check_settled(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_wr_en"}, log_wr_en, 1'b0);
        chk({tag, "_ptr"}, log_ptr, 32'(m_ptr));
        chk({tag, "_addr"}, log_addr, 32'(BASE + 16'(2 * m_ptr)));
        chk({tag, "_full"}, log_full, m_full);
        chk({tag, "_lost"}, evt_lost, m_lost);
        chk({tag, "_wr_count"}, wr_count, m_writes);
    endtask

    task automatic do_flush(input bit with_detect);
        flush = 1'b1;
        branch_detect = with_detect;
        step();
        flush = 1'b0;
        branch_detect = 1'b0;
        model_flush();
        check_settled("flush");
        $display("flush (detect=%0b): ptr=%0d full=%0b lost=%0b", with_detect, log_ptr, log_full, evt_lost);
    endtask

    // One branch event: detect at src, PC moves to newpc move_delay cycles
    // into the wait, each write stalled for 'stall' cycles before ack.
    task automatic do_event(input logic [15:0] src, input logic [15:0] newpc,
                            input int move_delay, input int stall, input bit inject_lost);
        int c;
        int res;
        int lat;
        logic [15:0] dst;
        logic [15:0] ea;
        evt_no++;
        pc = src;
        if (m_full) begin
            branch_detect = 1'b1;
            step();
            branch_detect = 1'b0;
            m_lost = 1'b1;
            chk("lost_in_full", evt_lost, 1'b1);
            chk("full_held", log_full, 1'b1);
            chk("full_no_wr", log_wr_en, 1'b0);
            chk("full_ptr", log_ptr, 32'(m_ptr));
            $display("event %0d: src=%h dropped while full, lost=%0b", evt_no, src, evt_lost);
            return;
        end
        if (m_ptr + 2 > LSIZE) begin
            branch_detect = 1'b1;
            step();
            branch_detect = 1'b0;
            m_full = 1'b1;
            chk("to_full_flag", log_full, 1'b1);
            chk("to_full_busy", busy, 1'b1);
            chk("to_full_lost", evt_lost, m_lost);
            step();
            step();
            chk("to_full_no_wr", log_wr_en, 1'b0);
            chk("to_full_wr_count", wr_count, m_writes);
            chk("to_full_ptr", log_ptr, 32'(m_ptr));
            $display("event %0d: src=%h log full at ptr=%0d", evt_no, src, log_ptr);
            return;
        end

        dst = (move_delay <= TMO - 1) ? newpc : src;
        lat = ((move_delay < TMO - 1) ? move_delay : TMO - 1) + 1;
        model_pair(src, dst, res);

        branch_detect = 1'b1;
        step();
        branch_detect = 1'b0;
        chk("busy_after_detect", busy, 1'b1);
        if (move_delay == 0) pc = newpc;
        c = 0;
        while (c < 40) begin
            step();
            c++;
            if (c == move_delay) pc = newpc;
            if (res == 0 && log_wr_en) break;
            if (res == 1 && !busy) break;
            if (res == 2 && log_full) break;
        end
        chk("decision_latency", c, lat);

        if (res == 2) begin
            chk("pair_full_flag", log_full, 1'b1);
            chk("pair_full_no_wr", log_wr_en, 1'b0);
            $display("event %0d: src=%h dst=%h no room for count word, full", evt_no, src, dst);
            return;
        end

        for (int i = 0; i < exp_q.size(); i++) begin
            ea = BASE + 16'(2 * m_ptr);
            chk("wr_en", log_wr_en, 1'b1);
            chk("wr_addr", log_addr, ea);
            chk("wr_data", log_wdata, exp_q[i]);
            for (int s = 0; s < stall; s++) begin
                step();
                chk("stall_wr_en", log_wr_en, 1'b1);
                chk("stall_addr", log_addr, ea);
                chk("stall_data", log_wdata, exp_q[i]);
            end
            if (inject_lost && i == exp_q.size() - 1) begin
                branch_detect = 1'b1;
                step();
                branch_detect = 1'b0;
                m_lost = 1'b1;
                chk("lost_while_busy", evt_lost, 1'b1);
            end
            log_wr_ack = 1'b1;
            step();
            log_wr_ack = 1'b0;
            m_ptr++;
            m_writes++;
        end
        check_settled("evt");
        $display("event %0d: src=%h dst=%h words=%0d ptr=%0d lost=%0b", evt_no, src, dst, exp_q.size(), log_ptr, evt_lost);
    endtask

    // Flush arriving together with the ack of the source write.
    task automatic flush_during_write(input logic [15:0] src, input logic [15:0] newpc);
        pc = src;
        branch_detect = 1'b1;
        step();
        branch_detect = 1'b0;
        pc = newpc;
        step();
        chk("fw_wr_en_before", log_wr_en, 1'b1);
        chk("fw_data_before", log_wdata, src);
        flush = 1'b1;
        log_wr_ack = 1'b1;
        step();
        flush = 1'b0;
        log_wr_ack = 1'b0;
        model_flush();
        check_settled("fw");
        $display("flush with ack in source write: ptr=%0d wr_en=%0b", log_ptr, log_wr_en);
    endtask

    initial begin
        logic [15:0] rs;
        logic [15:0] rn;
        reset = 1'b1;
        branch_detect = 1'b0;
        flush = 1'b0;
        log_wr_ack = 1'b0;
        pc = 16'h0000;
        repeat (3) step();
        chk("rst_wr_en", log_wr_en, 1'b0);
        chk("rst_addr", log_addr, BASE);
        chk("rst_wdata", log_wdata, 16'h0000);
        chk("rst_ptr", log_ptr, 16'h0000);
        chk("rst_full", log_full, 1'b0);
        chk("rst_lost", evt_lost, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        step();

        // Basic pair, immediate PC move and immediate acks.
        do_event(16'hE010, 16'hE200, 0, 0, 1'b0);
        // Ack stall of 5 cycles on every word.
        do_event(16'hE030, 16'hE034, 1, 5, 1'b0);
        // PC never moves: destination taken at the timeout.
        do_event(16'hE020, 16'hE022, 20, 0, 1'b0);
        // Event arriving during the destination write is lost.
        do_event(16'hE040, 16'hE050, 0, 1, 1'b1);
        // Log exhausted, then an event while full.
        do_event(16'hE060, 16'hE070, 0, 0, 1'b0);
        do_event(16'hE080, 16'hE090, 0, 0, 1'b0);
        do_flush(1'b0);
        // Flush wins over a simultaneous detect.
        do_flush(1'b1);
        flush_during_write(16'hE0A0, 16'hE0B0);

`ifdef CFLOG_LOOP_COMPRESS_EN
        do_flush(1'b0);
        repeat (4) do_event(16'hE100, 16'hE0F0, 0, 0, 1'b0);
        do_event(16'hE100, 16'hE120, 0, 0, 1'b0);
        chk("cmp_ptr", log_ptr, 16'd5);
        do_flush(1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            rs = 16'hC000 + 16'(i * 8);
            rn = rs + 16'(2 * $urandom_range(1, 200));
            do_event(rs, rn, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 5) == 0));
            if (m_full && m_lost) do_flush($urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
